mc_sequencer: RTL

- Multicycle control FSM for the 32-bit MIPS core. Replaces the single-cycle decode path when instruction and data share one memory port.
- Sequences fetch, decode, execute, memory and writeback over several cycles. Drives the PC/IR/register-file write enables, mux selects, ALU control and the memory request handshake.
- Sits between the shared memory port and the datapath registers (PC, IR, A/B, ALUOut, MDR).

---
 rtl/mc_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_sequencer.sv
// Multicycle control FSM for the 32-bit MIPS core sharing one memory port.
// Optional performance counters (cyc_cnt, ret_cnt) are enabled by defining MC_PERF_CNT_EN.
module mc_sequencer #(
    parameter int ACK_TIMEOUT = 15
`ifdef MC_PERF_CNT_EN
    ,
    parameter int PERF_W      = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic              iord,
    output logic              ir_we,
    output logic              mdr_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alc,
    output logic              we3,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              illegal,
    output logic              fault
`ifdef MC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] ret_cnt
`endif
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] ALC_ADD = 3'b010;
    localparam logic [2:0] ALC_SUB = 3'b110;
    localparam logic [2:0] ALC_AND = 3'b000;
    localparam logic [2:0] ALC_OR  = 3'b001;
    localparam logic [2:0] ALC_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_REXEC, S_RWB, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alc        = 3'b000;
        we3        = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                alc       = ALC_ADD;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = 2'd3;
                alc       = ALC_ADD;
                case (opcode)
                    6'h00:        state_d = S_REXEC;
                    6'h23, 6'h2B: state_d = S_MEMADR;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h08:        state_d = S_IEXEC;
                    6'h02:        state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_REXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_RWB;
                case (funct)
                    6'h20: alc = ALC_ADD;
                    6'h22: alc = ALC_SUB;
                    6'h24: alc = ALC_AND;
                    6'h25: alc = ALC_OR;
                    6'h2A: alc = ALC_SLT;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_RWB: begin
                we3     = 1'b1;
                reg_dst = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alc       = ALC_ADD;
                state_d   = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack) begin
                    mdr_we  = 1'b1;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                we3        = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ack) begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alc       = ALC_SUB;
                pc_src    = 2'd1;
                pc_we     = (opcode == 6'h04) ? zero : ~zero;
                state_d   = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alc       = ALC_ADD;
                state_d   = S_IWB;
            end
            S_IWB: begin
                we3     = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_src  = 2'd2;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // An ack in the same cycle the limit is reached takes priority over the fault.
        if (mem_req && !mem_ack) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d = S_FAULT;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_we      = 1'b0;
            mdr_we     = 1'b0;
            pc_we      = 1'b0;
            pc_src     = 2'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            alc        = 3'b000;
            we3        = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
            fault      = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [PERF_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [PERF_W-1:0] ret_cnt_q, ret_cnt_d;
    logic              retire;

    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_RWB, S_MEMWB, S_MEMWR, S_BRANCH, S_IWB, S_JUMP: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
        cyc_cnt_d = (state_q == S_FAULT) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
        ret_cnt_d = retire ? ret_cnt_q + 1'b1 : ret_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif

endmodule
